s2_receiver: RTL and testbench

S2_RECEIVER -- requirements
Module: s2_receiver

---
 rtl/s2_pkg.sv | 17 +
 rtl/s2_shift_in.sv | 21 ++
 rtl/s2_receiver.sv | 111 +++++++++++
 tb/tb_s2_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/s2_pkg.sv
// Shared definitions for the S2 serial receiver: frame geometry defaults
// and the receiver state encoding.
package s2_pkg;

  localparam int FRAME_ADDR_W_DEF = 3;
  localparam int FRAME_DATA_W_DEF = 18;
  localparam int FRAMES_TOTAL_DEF = 8;
  localparam int FRAME_BITS       = 21;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/s2_shift_in.sv
// Serial-in / parallel-out frame register. New bits enter at the LSB, so the
// first bit received ends up at the MSB once the frame is complete.
module s2_shift_in #(
  parameter int WIDTH = s2_pkg::FRAME_BITS
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/s2_receiver.sv
// Serial frame receiver: collects address+data frames framed by an active-low
// enable and issues a one-cycle write strobe into RB2 for each complete frame.
module s2_receiver
  import s2_pkg::*;
#(
  parameter int FRAME_ADDR_W = FRAME_ADDR_W_DEF,
  parameter int FRAME_DATA_W = FRAME_DATA_W_DEF,
  parameter int FRAMES_TOTAL = FRAMES_TOTAL_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sen,
  input  logic                    sd,
  output logic                    RB2_RW,
  output logic [FRAME_ADDR_W-1:0] RB2_A,
  output logic [FRAME_DATA_W-1:0] RB2_D,
  input  logic [FRAME_DATA_W-1:0] RB2_Q,
  output logic                    S2_done
);

  localparam int FB          = FRAME_ADDR_W + FRAME_DATA_W;
  localparam int BIT_CNT_W   = $clog2(FB + 1);
  localparam int FRAME_CNT_W = $clog2(FRAMES_TOTAL + 1);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_RECV    = ST_RECV;
  localparam logic [1:0] S_WAIT_HI = ST_WAIT_HI;
  localparam logic [1:0] S_DONE    = ST_DONE;

  logic [1:0]             state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FB-1:0]          frame_q;
  logic [FB-1:0]          frame_next;
  logic                   shift_en;
  logic                   shift_clear;
  logic                   last_bit;
  logic                   rb2_q_unused;

  // The frame register never feeds a write directly: the write data is the
  // register contents plus the bit being sampled on this same edge.
  assign frame_next  = {frame_q[FB-2:0], sd};
  assign shift_en    = !sen && (state == S_IDLE || state == S_RECV);
  assign shift_clear = rst || (state == S_RECV && sen);
  assign last_bit    = (state == S_RECV) && !sen && (bit_cnt == BIT_CNT_W'(FB - 1));

  assign rb2_q_unused = ^{RB2_Q, frame_q[FB-1]};

  s2_shift_in #(.WIDTH(FB)) u_shift_in (
    .clk      (clk),
    .clear    (shift_clear),
    .shift_en (shift_en),
    .din      (sd),
    .q        (frame_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      RB2_RW    <= 1'b1;
      RB2_A     <= '0;
      RB2_D     <= '0;
      S2_done   <= 1'b0;
    end else begin
      // The strobe is a single cycle: any cycle not issuing a write reads.
      RB2_RW <= 1'b1;
      case (state)
        S_IDLE: begin
          if (!sen) begin
            bit_cnt <= BIT_CNT_W'(1);
            state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (sen) begin
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else if (last_bit) begin
            RB2_A     <= frame_next[FB-1 -: FRAME_ADDR_W];
            RB2_D     <= frame_next[FRAME_DATA_W-1:0];
            RB2_RW    <= 1'b0;
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            bit_cnt   <= '0;
            state     <= S_WAIT_HI;
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        S_WAIT_HI: begin
          // Completion is taken on the edge that ends the final strobe,
          // whether or not the enable has been released yet.
          if (frame_cnt == FRAME_CNT_W'(FRAMES_TOTAL)) begin
            S2_done <= 1'b1;
            state   <= S_DONE;
          end else if (sen) begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          S2_done <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s2_receiver.sv
// Directed and randomized frame traffic for s2_receiver, checked against a
// frame-level model of which frames must produce RB2 writes.
module tb_s2_receiver;

  localparam int AW = 3;
  localparam int DW = 18;
  localparam int FW = AW + DW;
  localparam int TOTAL = 8;

  logic          clk;
  logic          rst;
  logic          sen;
  logic          sd;
  logic          rb2_rw;
  logic [AW-1:0] rb2_a;
  logic [DW-1:0] rb2_d;
  logic [DW-1:0] rb2_q;
  logic          s2_done;

  int errors = 0;
  int checks = 0;

  // Reference model state: writes that must appear, frames accepted, done flag.
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] obs_q[$];
  int            exp_cnt = 0;
  logic          exp_done = 1'b0;
  int            long_strobe = 0;
  logic          prev_rw = 1'b1;

  s2_receiver #(
    .FRAME_ADDR_W (AW),
    .FRAME_DATA_W (DW),
    .FRAMES_TOTAL (TOTAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sen     (sen),
    .sd      (sd),
    .RB2_RW  (rb2_rw),
    .RB2_A   (rb2_a),
    .RB2_D   (rb2_d),
    .RB2_Q   (rb2_q),
    .S2_done (s2_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe every write strobe and any strobe lasting more than one cycle.
  always @(negedge clk) begin
    if (!rst && rb2_rw === 1'b0) begin
      obs_q.push_back({rb2_a, rb2_d});
      if (prev_rw === 1'b0) long_strobe++;
    end
    prev_rw = rst ? 1'b1 : rb2_rw;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  function automatic void model_frame(input int nbits, input logic [FW-1:0] word);
    if (!exp_done && nbits >= FW) begin
      exp_q.push_back(word);
      exp_cnt++;
      if (exp_cnt == TOTAL) exp_done = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    exp_cnt  = 0;
    exp_done = 1'b0;
  endfunction

  function automatic logic [FW-1:0] mk_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {a, d};
  endfunction

  // Drives nbits enabled samples (frame bits MSB first, then filler), then gap idle cycles.
  task automatic send_frame(input int nbits, input logic [FW-1:0] word, input int gap, input logic fill_one);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sen = 1'b0;
      if (i < FW) sd = word[FW-1-i];
      else        sd = fill_one ? 1'b1 : 1'($urandom_range(0, 1));
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    repeat (2) @(negedge clk);
    check({tag, " write count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " write A/D"}, 64'(obs_q[i]), 64'(exp_q[i]));
    end
    check({tag, " strobe width"}, 64'(long_strobe), 64'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [FW-1:0] w;
    int            len;
    rst   = 1'b1;
    sen   = 1'b1;
    sd    = 1'b0;
    rb2_q = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset RB2_RW", 64'(rb2_rw), 64'd1);
    check("reset RB2_A", 64'(rb2_a), 64'd0);
    check("reset RB2_D", 64'(rb2_d), 64'd0);
    check("reset S2_done", 64'(s2_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame: strobe exactly in the cycle after bit 21
    w = mk_word(3'b101, 18'h2A5C3);
    send_frame(FW, w, 0, 1'b0);
    model_frame(FW, w);
    @(negedge clk);
    check("strobe RB2_RW low", 64'(rb2_rw), 64'd0);
    check("strobe RB2_A", 64'(rb2_a), 64'd5);
    check("strobe RB2_D", 64'(rb2_d), 64'h2A5C3);
    sen = 1'b1;
    @(negedge clk);
    check("strobe ends", 64'(rb2_rw), 64'd1);
    check("RB2_A holds", 64'(rb2_a), 64'd5);
    check("RB2_D holds", 64'(rb2_d), 64'h2A5C3);
    check_writes("single");

    // Short frame discarded, then a valid frame
    send_frame(10, FW'($urandom), 1, 1'b0);
    w = mk_word(3'd2, 18'h3FFFF);
    send_frame(FW, w, 1, 1'b0);
    model_frame(10, '0);
    model_frame(FW, w);
    check_writes("short+valid");
    check("frame_cnt after short", 64'(dut.frame_cnt), 64'(exp_cnt));

    // Over-long frame: exactly one write, then idle before the next frame
    w = mk_word(3'd7, 18'h3FFFF);
    send_frame(25, w, 1, 1'b1);
    model_frame(25, w);
    check_writes("overlong");

    // Randomized frame lengths and contents, back-to-back with one idle cycle
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(15, 24);
      w   = mk_word(AW'($urandom), DW'($urandom));
      send_frame(len, w, 1, 1'b0);
      model_frame(len, w);
    end
    check_writes("random");
    check("frame_cnt random", 64'(dut.frame_cnt), 64'(exp_cnt));

    // Reset in the middle of a frame, then a full frame
    send_frame(11, FW'($urandom), 0, 1'b0);
    @(negedge clk);
    sen = 1'b0;
    sd  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sen = 1'b1;
    model_reset();
    check_writes("mid-frame reset");
    check("frame_cnt after rst", 64'(dut.frame_cnt), 64'd0);
    w = mk_word(3'd1, 18'h00001);
    send_frame(FW, w, 1, 1'b0);
    model_frame(FW, w);
    check_writes("after reset");
    check("S2_done after reset", 64'(s2_done), 64'd0);

    // Eight frames to completion
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < TOTAL - 1; a++) begin
      w = mk_word(AW'(a), DW'(a * 18'h01111));
      send_frame(FW, w, 1, 1'b0);
      model_frame(FW, w);
    end
    check("S2_done before 8th", 64'(s2_done), 64'd0);
    w = mk_word(AW'(TOTAL - 1), DW'((TOTAL - 1) * 18'h01111));
    send_frame(FW, w, 0, 1'b0);
    model_frame(FW, w);
    @(negedge clk);
    check("8th strobe", 64'(rb2_rw), 64'd0);
    check("S2_done during 8th", 64'(s2_done), 64'd0);
    sen = 1'b1;
    @(negedge clk);
    check("S2_done after 8th", 64'(s2_done), 64'(exp_done));
    check_writes("eight frames");
    check("frame_cnt at done", 64'(dut.frame_cnt), 64'(exp_cnt));

    // Frames after completion are ignored
    w = mk_word(AW'($urandom), DW'($urandom));
    send_frame(FW, w, 1, 1'b0);
    model_frame(FW, w);
    check_writes("after done");
    check("RB2_RW after done", 64'(rb2_rw), 64'd1);
    check("S2_done sticky", 64'(s2_done), 64'(exp_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
